// File: rtl/piano_key_frontend_if.sv
// Key inputs and display/status outputs of the piano key front end.
// The master side drives the raw keys; the slave side is the front end itself.
interface piano_key_frontend_if #(
    parameter int NUM_KEYS = 7
);
    logic [NUM_KEYS-1:0] note_keys_raw;
    logic                octave_up_raw;
    logic                octave_down_raw;
    logic [2:0]          active_key_id;
    logic                key_is_pressed;
    logic                octave_up_active;
    logic                octave_down_active;
    logic                seg_a;
    logic                seg_b;
    logic                seg_c;
    logic                seg_d;
    logic                seg_e;
    logic                seg_f;
    logic                seg_g;
    logic                seg_dp;
    logic [7:0]          digit_selects;

    modport master (
        output note_keys_raw, octave_up_raw, octave_down_raw,
        input  active_key_id, key_is_pressed, octave_up_active, octave_down_active,
        input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, digit_selects
    );

    modport slave (
        input  note_keys_raw, octave_up_raw, octave_down_raw,
        output active_key_id, key_is_pressed, octave_up_active, octave_down_active,
        output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, digit_selects
    );
endinterface

// File: rtl/piano_key_frontend.sv
// Piano key front end: synchronizes and debounces the note and octave keys,
// encodes the highest-priority note key, and multiplexes an 8-digit
// seven-segment display showing the note (digit 0) and octave (digit 1).
module piano_key_frontend #(
    parameter int NUM_KEYS          = 7,
    parameter int DEBOUNCE_TIME_MS  = 20,
    parameter int CYCLES_PER_MS     = 50000,
    parameter int DIGIT_HOLD_CYCLES = 50000
) (
    input  logic                 clk_50mhz,
    input  logic                 rst_n_internal,
    piano_key_frontend_if.slave  bus
);

    localparam int NUM_IN = NUM_KEYS + 2;
    localparam int N      = DEBOUNCE_TIME_MS * CYCLES_PER_MS;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int HOLD_W = $clog2(DIGIT_HOLD_CYCLES + 1);

    // Bit order: note keys in the low bits, then octave-up, then octave-down.
    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] sync_1;
    logic [NUM_IN-1:0] sync_2;
    logic [NUM_IN-1:0] db;

    assign raw_in = {bus.octave_down_raw, bus.octave_up_raw, bus.note_keys_raw};

    // Two-flop synchronizer on every raw key input
    always_ff @(posedge clk_50mhz or negedge rst_n_internal) begin
        if (!rst_n_internal) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt;
        logic             level;

        // Counts consecutive cycles the input disagrees with the output; any agreement restarts it
        always_ff @(posedge clk_50mhz or negedge rst_n_internal) begin
            if (!rst_n_internal) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync_2[i] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(N - 1)) begin
                cnt   <= '0;
                level <= sync_2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign db[i] = level;
    end

    logic [NUM_KEYS-1:0] note_db;
    logic [2:0]          next_id;
    logic [2:0]          key_id_q;
    logic                pressed_q;

    assign note_db = db[NUM_KEYS-1:0];

    // Fixed priority: the lowest-index pressed key wins
    always_comb begin
        next_id = 3'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (note_db[i]) next_id = 3'(i + 1);
        end
    end

    // Registered scanner outputs
    always_ff @(posedge clk_50mhz or negedge rst_n_internal) begin
        if (!rst_n_internal) begin
            key_id_q  <= 3'd0;
            pressed_q <= 1'b0;
        end else begin
            key_id_q  <= next_id;
            pressed_q <= |note_db;
        end
    end

    assign bus.active_key_id      = key_id_q;
    assign bus.key_is_pressed     = pressed_q;
    assign bus.octave_up_active   = db[NUM_KEYS];
    assign bus.octave_down_active = db[NUM_KEYS+1];

    function automatic logic [6:0] glyph(input logic [2:0] d);
        case (d)
            3'd1:    glyph = 7'b0110000;
            3'd2:    glyph = 7'b1101101;
            3'd3:    glyph = 7'b1111001;
            3'd4:    glyph = 7'b0110011;
            3'd5:    glyph = 7'b1011011;
            3'd6:    glyph = 7'b1011111;
            3'd7:    glyph = 7'b1110000;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        digit_idx;
    logic [6:0]        next_seg;
    logic [6:0]        seg_q;
    logic [7:0]        sel_q;

    // Digit index advances once every DIGIT_HOLD_CYCLES cycles, wrapping 7 -> 0
    always_ff @(posedge clk_50mhz or negedge rst_n_internal) begin
        if (!rst_n_internal) begin
            hold_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (hold_cnt == HOLD_W'(DIGIT_HOLD_CYCLES - 1)) begin
            hold_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Segment pattern for the digit currently being scanned
    always_comb begin
        next_seg = 7'b0000000;
        case (digit_idx)
            3'd0: next_seg = pressed_q ? glyph(key_id_q) : 7'b0000000;
            3'd1: begin
                if (db[NUM_KEYS] && !db[NUM_KEYS+1])      next_seg = glyph(3'd5);
                else if (!db[NUM_KEYS] && db[NUM_KEYS+1]) next_seg = glyph(3'd3);
                else                                      next_seg = glyph(3'd4);
            end
            default: next_seg = 7'b0000000;
        endcase
    end

    // Segments and select registered together so a digit never shows its neighbour's pattern
    always_ff @(posedge clk_50mhz or negedge rst_n_internal) begin
        if (!rst_n_internal) begin
            seg_q <= 7'b0000000;
            sel_q <= 8'hFF;
        end else begin
            seg_q <= next_seg;
            sel_q <= ~(8'd1 << digit_idx);
        end
    end

    assign bus.seg_a         = seg_q[6];
    assign bus.seg_b         = seg_q[5];
    assign bus.seg_c         = seg_q[4];
    assign bus.seg_d         = seg_q[3];
    assign bus.seg_e         = seg_q[2];
    assign bus.seg_f         = seg_q[1];
    assign bus.seg_g         = seg_q[0];
    assign bus.seg_dp        = 1'b0;
    assign bus.digit_selects = sel_q;

endmodule

// File: tb/tb_piano_key_frontend.sv
// Bench for piano_key_frontend: directed scenarios followed by random key
// activity, checked every cycle against a behavioural model through a queue.
module tb_piano_key_frontend;

    localparam int NUM_KEYS = 7;
    localparam int DMS      = 2;
    localparam int CPM      = 10;
    localparam int HOLD     = 4;
    localparam int N        = DMS * CPM;
    localparam int NUM_IN   = NUM_KEYS + 2;

    logic clk_50mhz      = 1'b0;
    logic rst_n_internal = 1'b0;

    piano_key_frontend_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    piano_key_frontend #(
        .NUM_KEYS         (NUM_KEYS),
        .DEBOUNCE_TIME_MS (DMS),
        .CYCLES_PER_MS    (CPM),
        .DIGIT_HOLD_CYCLES(HOLD)
    ) dut (
        .clk_50mhz     (clk_50mhz),
        .rst_n_internal(rst_n_internal),
        .bus           (bus)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    typedef struct packed {
        logic [2:0] id;
        logic       pressed;
        logic       up;
        logic       down;
        logic [7:0] sel;
        logic [6:0] segs;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // index = digit value, 0 = blank
    logic [6:0] glyph_tab [0:7] = '{7'b0000000, 7'b0110000, 7'b1101101, 7'b1111001,
                                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    endtask

    function automatic logic [2:0] lowest_key(input logic [NUM_KEYS-1:0] k);
        for (int i = 0; i < NUM_KEYS; i++) if (k[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    function automatic logic [6:0] octave_glyph(input logic up, input logic down);
        if (up && !down) return 7'b1011011;
        if (down && !up) return 7'b1111001;
        return 7'b0110011;
    endfunction

    // Reference model: an input's level flips once its raw value (seen two
    // cycles late) has held the opposite value for N cycles in a row.
    initial begin : model
        logic [NUM_IN-1:0] d1, d2, o, prev_o, lvl, lvl_old;
        int                run [NUM_IN];
        int                edges;
        logic [2:0]        prev_id;
        logic              prev_pressed, prev_up, prev_down;
        int                digit;
        exp_t              e;
        d1 = '0; d2 = '0; prev_o = '0; lvl = '0; edges = 0;
        prev_id = 0; prev_pressed = 0; prev_up = 0; prev_down = 0;
        for (int i = 0; i < NUM_IN; i++) run[i] = 0;
        forever begin
            @(posedge clk_50mhz);
            if (!rst_n_internal) begin
                d1 = '0; d2 = '0; prev_o = '0; lvl = '0; edges = 0;
                prev_id = 0; prev_pressed = 0; prev_up = 0; prev_down = 0;
                for (int i = 0; i < NUM_IN; i++) run[i] = 0;
                e = '0;
                e.sel = 8'hFF;
            end else begin
                o  = d2;
                d2 = d1;
                d1 = {bus.octave_down_raw, bus.octave_up_raw, bus.note_keys_raw};
                lvl_old = lvl;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (o[i] == prev_o[i]) run[i] = (run[i] < N) ? run[i] + 1 : N;
                    else run[i] = 1;
                    prev_o[i] = o[i];
                    if (run[i] >= N && o[i] != lvl[i]) lvl[i] = o[i];
                end
                e.id      = lowest_key(lvl_old[NUM_KEYS-1:0]);
                e.pressed = |lvl_old[NUM_KEYS-1:0];
                e.up      = lvl[NUM_KEYS];
                e.down    = lvl[NUM_KEYS+1];
                digit     = (edges / HOLD) % 8;
                e.sel     = ~(8'd1 << digit);
                if (digit == 0)      e.segs = prev_pressed ? glyph_tab[prev_id] : 7'b0;
                else if (digit == 1) e.segs = octave_glyph(prev_up, prev_down);
                else                 e.segs = 7'b0;
                e.dp         = 1'b0;
                prev_id      = e.id;
                prev_pressed = e.pressed;
                prev_up      = e.up;
                prev_down    = e.down;
                edges++;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: each cycle the DUT presents a new output set; pop and compare
    initial begin : monitor
        exp_t       e;
        logic [6:0] segs;
        forever begin
            @(posedge clk_50mhz);
            #2;
            segs = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g};
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("key_id_pressed", {bus.active_key_id, bus.key_is_pressed}, {e.id, e.pressed});
                check("octave_levels", {bus.octave_up_active, bus.octave_down_active}, {e.up, e.down});
                check("display_sel_segs", {bus.digit_selects, segs, bus.seg_dp}, {e.sel, e.segs, e.dp});
                if (rst_n_internal)
                    check("one_digit_selected", $countones(~bus.digit_selects), 1);
            end
        end
    end

    task automatic hold(input logic [NUM_KEYS-1:0] k, input logic up, input logic down, input int n);
        bus.note_keys_raw   = k;
        bus.octave_up_raw   = up;
        bus.octave_down_raw = down;
        repeat (n) @(negedge clk_50mhz);
    endtask

    initial begin : stimulus
        logic [6:0] segs;
        bus.note_keys_raw   = '0;
        bus.octave_up_raw   = 1'b0;
        bus.octave_down_raw = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        rst_n_internal = 1'b1;

        hold(7'b0000100, 0, 0, N + 10);   // key 3 pressed
        hold(7'b0000000, 0, 0, N + 10);   // released
        hold(7'b0000001, 0, 0, 10);       // short pulse on key 1 is filtered
        hold(7'b0000000, 0, 0, 5);
        hold(7'b1000010, 0, 0, N + 10);   // keys 2 and 7: key 2 wins
        hold(7'b0000000, 1, 0, N + 10);   // octave up -> '5'
        hold(7'b0000000, 1, 1, N + 10);   // both -> '4'
        hold(7'b0000000, 0, 1, N + 10);   // down only -> '3'
        hold(7'b1000000, 0, 0, N + 40);   // key 7, full scan of all digits
        hold(7'b0000000, 0, 0, N + 10);   // release all

        // Reset mid-debounce with keys held: outputs must clear at once
        hold(7'b0010000, 1, 0, N + 10);
        hold(7'b0001000, 1, 0, 10);
        #2;
        rst_n_internal = 1'b0;
        #1;
        segs = {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g};
        check("reset_key_outputs", {bus.active_key_id, bus.key_is_pressed}, 4'b0000);
        check("reset_octave_outputs", {bus.octave_up_active, bus.octave_down_active}, 2'b00);
        check("reset_display", {bus.digit_selects, segs, bus.seg_dp}, {8'hFF, 7'b0, 1'b0});
        @(negedge clk_50mhz);
        repeat (3) @(negedge clk_50mhz);
        rst_n_internal = 1'b1;
        hold(7'b0001000, 1, 0, N + 10);   // re-debounce from scratch

        // Random activity: mixed short glitches and long holds, occasional reset
        for (int s = 0; s < 90; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n_internal = 1'b0;
                repeat (2) @(negedge clk_50mhz);
                rst_n_internal = 1'b1;
            end
            hold(7'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, N + 15));
        end
        hold(7'b0000000, 0, 0, N + 10);

        @(negedge clk_50mhz);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
